// File: rtl/beta_dmem_ctrl.sv
// Beta data-side memory controller: one load/store at a time against a synchronous-read SRAM.
// Store stalls W+1 cycles, load W+2 cycles; Beta is held via stall until the final response cycle.
module beta_dmem_ctrl #(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [31:0]              ma,
    input  logic [31:0]              mwd,
    input  logic                     moe,
    input  logic                     wr,
    output logic [31:0]              mrd,
    output logic                     stall,
    output logic                     bus_err,
    output logic [$clog2(DEPTH)-1:0] sram_addr,
    output logic [31:0]              sram_wdata,
    output logic                     sram_we,
    output logic                     sram_re,
    input  logic [31:0]              sram_rdata,
    output logic [15:0]              rd_count,
    output logic [15:0]              wr_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, ACCESS, RESP} state_t;

    localparam logic [3:0] WAIT_INIT   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam state_t     AFTER_IDLE  = (WAIT_STATES > 0) ? BUSY : ACCESS;

    state_t      state;
    logic [29:0] addr_q;
    logic [31:0] data_q;
    logic        is_wr_q;
    logic        err_q;
    logic [3:0]  wait_cnt;
    logic [31:0] mrd_q;

    logic req;
    logic oor;
    logic unused_ok;

    assign req       = moe | wr;
    assign oor       = |addr_q[29:AW];
    assign unused_ok = ^ma[1:0];

    assign sram_addr  = addr_q[AW-1:0];
    assign sram_wdata = data_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            is_wr_q  <= 1'b0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
            mrd_q    <= '0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q   <= ma[31:2];
                        data_q   <= mwd;
                        is_wr_q  <= wr;
                        err_q    <= 1'b0;
                        wait_cnt <= WAIT_INIT;
                        state    <= AFTER_IDLE;
                    end
                end
                BUSY: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ACCESS: begin
                    if (is_wr_q) begin
                        // Out-of-range stores are dropped but still count as completed.
                        if (wr_count != 16'hFFFF) begin
                            wr_count <= wr_count + 16'd1;
                        end
                        state <= IDLE;
                    end else begin
                        err_q <= oor;
                        state <= RESP;
                    end
                end
                RESP: begin
                    mrd_q <= err_q ? ERR_DATA : sram_rdata;
                    if (rd_count != 16'hFFFF) begin
                        rd_count <= rd_count + 16'd1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall   = 1'b0;
        bus_err = 1'b0;
        sram_we = 1'b0;
        sram_re = 1'b0;
        mrd     = mrd_q;
        case (state)
            IDLE:   stall = req & ~RST;
            BUSY:   stall = 1'b1;
            ACCESS: begin
                stall   = ~is_wr_q;
                sram_we = is_wr_q & ~oor;
                sram_re = ~is_wr_q & ~oor;
                bus_err = is_wr_q & oor;
            end
            RESP: begin
                // Read data is only valid during RESP, so it bypasses the holding register.
                mrd     = err_q ? ERR_DATA : sram_rdata;
                bus_err = err_q;
            end
            default: stall = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_beta_dmem_ctrl.sv
// Directed bench for beta_dmem_ctrl: one instance with two wait states, one with none.
module tb_beta_dmem_ctrl;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic        moe_r, wr_r, sel;
    logic [31:0] ma, mwd;

    logic [31:0] mrd_a, sram_wdata_a, sram_rdata_a;
    logic        stall_a, bus_err_a, sram_we_a, sram_re_a;
    logic [9:0]  sram_addr_a;
    logic [15:0] rd_count_a, wr_count_a;

    logic [31:0] mrd_b, sram_wdata_b, sram_rdata_b;
    logic        stall_b, bus_err_b, sram_we_b, sram_re_b;
    logic [3:0]  sram_addr_b;
    logic [15:0] rd_count_b, wr_count_b;

    logic moe_a, wr_a, moe_b, wr_b;
    assign moe_a = moe_r & ~sel;
    assign wr_a  = wr_r  & ~sel;
    assign moe_b = moe_r &  sel;
    assign wr_b  = wr_r  &  sel;

    beta_dmem_ctrl #(.DEPTH(1024), .WAIT_STATES(2), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .CLK(CLK), .RST(RST), .ma(ma), .mwd(mwd), .moe(moe_a), .wr(wr_a),
        .mrd(mrd_a), .stall(stall_a), .bus_err(bus_err_a),
        .sram_addr(sram_addr_a), .sram_wdata(sram_wdata_a), .sram_we(sram_we_a),
        .sram_re(sram_re_a), .sram_rdata(sram_rdata_a),
        .rd_count(rd_count_a), .wr_count(wr_count_a)
    );

    beta_dmem_ctrl #(.DEPTH(16), .WAIT_STATES(0), .ERR_DATA(32'hDEAD_BEEF)) dut0 (
        .CLK(CLK), .RST(RST), .ma(ma), .mwd(mwd), .moe(moe_b), .wr(wr_b),
        .mrd(mrd_b), .stall(stall_b), .bus_err(bus_err_b),
        .sram_addr(sram_addr_b), .sram_wdata(sram_wdata_b), .sram_we(sram_we_b),
        .sram_re(sram_re_b), .sram_rdata(sram_rdata_b),
        .rd_count(rd_count_b), .wr_count(wr_count_b)
    );

    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [16];

    always @(posedge CLK) begin
        if (sram_we_a) mem_a[sram_addr_a] <= sram_wdata_a;
        if (sram_re_a) sram_rdata_a <= mem_a[sram_addr_a];
        if (sram_we_b) mem_b[sram_addr_b] <= sram_wdata_b;
        if (sram_re_b) sram_rdata_b <= mem_b[sram_addr_b];
    end

    // View of whichever instance the current test is driving.
    logic        v_stall, v_err, v_we, v_re;
    logic [31:0] v_mrd, v_addr, v_wdata;
    assign v_stall = sel ? stall_b   : stall_a;
    assign v_err   = sel ? bus_err_b : bus_err_a;
    assign v_we    = sel ? sram_we_b : sram_we_a;
    assign v_re    = sel ? sram_re_b : sram_re_a;
    assign v_mrd   = sel ? mrd_b     : mrd_a;
    assign v_addr  = sel ? {28'd0, sram_addr_b} : {22'd0, sram_addr_a};
    assign v_wdata = sel ? sram_wdata_b : sram_wdata_a;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    // Presents one request and follows it to its stall=0 cycle; returns one cycle later
    // with the request still asserted so the caller can chain or drop it.
    task automatic run_req(input logic l_moe, input logic l_wr, input logic [31:0] a,
                           input logic [31:0] d, input bit scramble,
                           output int ns, output int nwe, output int nre, output int nerr,
                           output logic last_err, output logic [31:0] last_mrd,
                           output logic [31:0] we_addr, output logic [31:0] we_data);
        bit done;
        done = 0; ns = 0; nwe = 0; nre = 0; nerr = 0;
        last_err = 1'b0; last_mrd = '0; we_addr = '0; we_data = '0;
        moe_r = l_moe; wr_r = l_wr; ma = a; mwd = d;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (v_we) begin nwe++; we_addr = v_addr; we_data = v_wdata; end
            if (v_re) nre++;
            if (v_err) nerr++;
            if (!v_stall) begin
                last_err = v_err; last_mrd = v_mrd; done = 1;
            end else begin
                ns++;
            end
            cyc();
            if (done) break;
            if (scramble) begin ma = 32'hFFFF_FFFC; mwd = 32'h0BAD_0BAD; end
        end
        n_assert++;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout: stall still %0b after 40 cycles, required completion", v_stall);
        end
    endtask

    int ns, nwe, nre, nerr;
    logic lerr;
    logic [31:0] lmrd, waddr, wdata;

    task automatic test_reset();
        RST = 1'b1; moe_r = 0; wr_r = 0; sel = 0; ma = '0; mwd = '0;
        #3;
        repeat (3) cyc();
        #1;
        n_assert++;
        if ({stall_a, bus_err_a, sram_we_a, sram_re_a} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b required 0000",
                               {stall_a, bus_err_a, sram_we_a, sram_re_a});
        end
        RST = 1'b0;
        cyc(); #1;
        n_assert++;
        if (mrd_a !== 32'd0 || sram_addr_a !== 10'd0 || sram_wdata_a !== 32'd0) begin
            n_fail++; $display("FAIL reset_data: mrd=%h addr=%h wdata=%h required 0",
                               mrd_a, sram_addr_a, sram_wdata_a);
        end
        n_assert++;
        if (rd_count_a !== 16'd0 || wr_count_a !== 16'd0 || rd_count_b !== 16'd0) begin
            n_fail++; $display("FAIL reset_cnt: rd=%0d wr=%0d rd0=%0d required 0",
                               rd_count_a, wr_count_a, rd_count_b);
        end
        n_assert++;
        if ({stall_a, sram_we_a, sram_re_a, stall_b} !== 4'b0) begin
            n_fail++; $display("FAIL idle_ctl: got %b required 0000",
                               {stall_a, sram_we_a, sram_re_a, stall_b});
        end
        #1;
    endtask

    task automatic test_store_load();
        sel = 0;
        run_req(1'b0, 1'b1, 32'h10, 32'hCAFE_0001, 1'b1, ns, nwe, nre, nerr, lerr, lmrd, waddr, wdata);
        n_assert++;
        if (ns !== 3 || nwe !== 1 || nre !== 0 || nerr !== 0) begin
            n_fail++; $display("FAIL store_cycles: stall=%0d we=%0d re=%0d err=%0d required 3 1 0 0",
                               ns, nwe, nre, nerr);
        end
        n_assert++;
        if (waddr !== 32'd4 || wdata !== 32'hCAFE_0001) begin
            n_fail++; $display("FAIL store_latched: addr=%h data=%h required 4 cafe0001", waddr, wdata);
        end
        run_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, ns, nwe, nre, nerr, lerr, lmrd, waddr, wdata);
        moe_r = 0; wr_r = 0;
        n_assert++;
        if (ns !== 4 || nre !== 1 || nwe !== 0 || lmrd !== 32'hCAFE_0001) begin
            n_fail++; $display("FAIL load: stall=%0d re=%0d we=%0d mrd=%h required 4 1 0 cafe0001",
                               ns, nre, nwe, lmrd);
        end
        cyc(); #1;
        n_assert++;
        if (rd_count_a !== 16'd1 || wr_count_a !== 16'd1 || mrd_a !== 32'hCAFE_0001) begin
            n_fail++; $display("FAIL counts_1: rd=%0d wr=%0d mrd=%h required 1 1 cafe0001",
                               rd_count_a, wr_count_a, mrd_a);
        end
        #1;
    endtask

    task automatic test_back_to_back();
        time t0;
        sel = 1;
        run_req(1'b0, 1'b1, 32'h0, 32'h1111_0000, 1'b0, ns, nwe, nre, nerr, lerr, lmrd, waddr, wdata);
        n_assert++;
        if (ns !== 1 || nwe !== 1) begin
            n_fail++; $display("FAIL w0_store: stall=%0d we=%0d required 1 1", ns, nwe);
        end
        run_req(1'b0, 1'b1, 32'h4, 32'h2222_0001, 1'b0, ns, nwe, nre, nerr, lerr, lmrd, waddr, wdata);
        t0 = $time;
        run_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, ns, nwe, nre, nerr, lerr, lmrd, waddr, wdata);
        n_assert++;
        if (ns !== 2 || lmrd !== 32'h1111_0000) begin
            n_fail++; $display("FAIL b2b_load0: stall=%0d mrd=%h required 2 11110000", ns, lmrd);
        end
        run_req(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, ns, nwe, nre, nerr, lerr, lmrd, waddr, wdata);
        moe_r = 0;
        n_assert++;
        if (ns !== 2 || lmrd !== 32'h2222_0001) begin
            n_fail++; $display("FAIL b2b_load1: stall=%0d mrd=%h required 2 22220001", ns, lmrd);
        end
        n_assert++;
        if ($time - t0 !== 60) begin
            n_fail++; $display("FAIL b2b_gap: elapsed=%0t required 60", $time - t0);
        end
        #1;
        n_assert++;
        if (rd_count_b !== 16'd2 || wr_count_b !== 16'd2) begin
            n_fail++; $display("FAIL w0_counts: rd=%0d wr=%0d required 2 2", rd_count_b, wr_count_b);
        end
        sel = 0;
        cyc();
    endtask

    task automatic test_out_of_range();
        sel = 0;
        run_req(1'b1, 1'b0, 32'h1000, 32'h0, 1'b0, ns, nwe, nre, nerr, lerr, lmrd, waddr, wdata);
        moe_r = 0;
        n_assert++;
        if (ns !== 4 || nre !== 0 || lmrd !== 32'hDEAD_BEEF || nerr !== 1 || lerr !== 1'b1) begin
            n_fail++; $display("FAIL oor_load: stall=%0d re=%0d mrd=%h err=%0d last=%b required 4 0 deadbeef 1 1",
                               ns, nre, lmrd, nerr, lerr);
        end
        run_req(1'b0, 1'b1, 32'h1000, 32'h1234_5678, 1'b0, ns, nwe, nre, nerr, lerr, lmrd, waddr, wdata);
        wr_r = 0;
        n_assert++;
        if (ns !== 3 || nwe !== 0 || nerr !== 1 || lerr !== 1'b1) begin
            n_fail++; $display("FAIL oor_store: stall=%0d we=%0d err=%0d last=%b required 3 0 1 1",
                               ns, nwe, nerr, lerr);
        end
        #1;
        n_assert++;
        if (rd_count_a !== 16'd2 || wr_count_a !== 16'd2 || bus_err_a !== 1'b0) begin
            n_fail++; $display("FAIL oor_counts: rd=%0d wr=%0d err=%b required 2 2 0",
                               rd_count_a, wr_count_a, bus_err_a);
        end
        cyc();
    endtask

    task automatic test_both_requests();
        sel = 0;
        run_req(1'b1, 1'b1, 32'h20, 32'h5A5A_1234, 1'b0, ns, nwe, nre, nerr, lerr, lmrd, waddr, wdata);
        moe_r = 0; wr_r = 0;
        n_assert++;
        if (ns !== 3 || nwe !== 1 || nre !== 0 || waddr !== 32'd8) begin
            n_fail++; $display("FAIL both_req: stall=%0d we=%0d re=%0d addr=%h required 3 1 0 8",
                               ns, nwe, nre, waddr);
        end
        #1;
        n_assert++;
        if (rd_count_a !== 16'd2 || wr_count_a !== 16'd3) begin
            n_fail++; $display("FAIL both_counts: rd=%0d wr=%0d required 2 3", rd_count_a, wr_count_a);
        end
        cyc();
        run_req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, ns, nwe, nre, nerr, lerr, lmrd, waddr, wdata);
        moe_r = 0;
        n_assert++;
        if (lmrd !== 32'h5A5A_1234) begin
            n_fail++; $display("FAIL both_readback: mrd=%h required 5a5a1234", lmrd);
        end
        cyc();
    endtask

    task automatic test_reset_in_busy();
        int we_seen;
        sel = 0; we_seen = 0;
        wr_r = 1; ma = 32'h30; mwd = 32'h0000_0077;
        #1;
        n_assert++;
        if (stall_a !== 1'b1) begin
            n_fail++; $display("FAIL rst_accept: stall=%b required 1", stall_a);
        end
        cyc();
        RST = 1'b1;
        #1;
        n_assert++;
        if (stall_a !== 1'b0 || sram_we_a !== 1'b0) begin
            n_fail++; $display("FAIL rst_stall: stall=%b we=%b required 0 0", stall_a, sram_we_a);
        end
        n_assert++;
        if (rd_count_a !== 16'd0 || wr_count_a !== 16'd0 || mrd_a !== 32'd0) begin
            n_fail++; $display("FAIL rst_clear: rd=%0d wr=%0d mrd=%h required 0 0 0",
                               rd_count_a, wr_count_a, mrd_a);
        end
        wr_r = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i == 1) RST = 1'b0;
            #1;
            if (sram_we_a) we_seen++;
            #1;
        end
        n_assert++;
        if (we_seen !== 0) begin
            n_fail++; $display("FAIL rst_no_write: we pulses=%0d required 0", we_seen);
        end
        run_req(1'b0, 1'b1, 32'h30, 32'h0000_0088, 1'b0, ns, nwe, nre, nerr, lerr, lmrd, waddr, wdata);
        run_req(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, ns, nwe, nre, nerr, lerr, lmrd, waddr, wdata);
        moe_r = 0;
        #1;
        n_assert++;
        if (ns !== 4 || lmrd !== 32'h0000_0088 || rd_count_a !== 16'd1 || wr_count_a !== 16'd1) begin
            n_fail++; $display("FAIL post_rst: stall=%0d mrd=%h rd=%0d wr=%0d required 4 88 1 1",
                               ns, lmrd, rd_count_a, wr_count_a);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_out_of_range();
        test_both_requests();
        test_reset_in_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/beta_dmem_ctrl.md
Name: beta_dmem_ctrl

Overview:
Data-memory controller directly downstream of the Beta processor's data-side memory port. It accepts one load or store at a time from the Beta. It holds the Beta via a stall signal while the access completes against a word-addressed, synchronous-read SRAM with programmable wait states. It also keeps saturating load/store counters for the verification environment.

Parameters:
DEPTH, 1024, number of 32-bit SRAM words; power of two, at least 2.
WAIT_STATES, 2, extra BUSY cycles inserted before each SRAM access; range 0..15.
ERR_DATA, 32'hDEAD_BEEF, value returned on mrd for an out-of-range load.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST  in  1  asynchronous, active-high reset.
ma  in  32  Beta byte address; ma[1:0] ignored, word index = ma[31:2].
mwd  in  32  Beta store data.
moe  in  1  Beta load request, held until stall deasserts.
wr  in  1  Beta store request, held until stall deasserts.
mrd  out  32  load data returned to the Beta.
stall  out  1  holds the Beta pipeline while a request is in flight.
bus_err  out  1  one-cycle pulse when an access is out of range.
sram_addr  out  $clog2(DEPTH)  SRAM word address.
sram_wdata  out  32  SRAM write data.
sram_we  out  1  SRAM write strobe, one cycle.
sram_re  out  1  SRAM read strobe, one cycle; data is valid on sram_rdata the next cycle.
sram_rdata  in  32  SRAM read data.
rd_count  out  16  completed loads, saturating at 16'hFFFF.
wr_count  out  16  completed stores, saturating at 16'hFFFF.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state returns to IDLE.
  - stall, bus_err, sram_we and sram_re drop to 0.
  - mrd, sram_addr, sram_wdata, rd_count and wr_count clear to 0.
  - A request in flight when RST asserts is abandoned; no SRAM write occurs.
- States: IDLE, BUSY, ACCESS, RESP.
- IDLE:
  - A request is present when moe or wr is 1.
  - stall is combinational: stall = req in IDLE.
  - On the edge, latch ma[31:2], mwd and the request type into registers. If both wr and moe are high, wr wins and moe is ignored.
  - Next state is BUSY if WAIT_STATES > 0, else ACCESS. The wait counter loads WAIT_STATES-1.
- BUSY:
  - stall = 1.
  - The counter decrements each cycle; at 0, go to ACCESS.
- ACCESS, in range (word index < DEPTH):
  - Drive sram_addr from the latched address.
  - Store: sram_we = 1 and sram_wdata = latched mwd; stall = 0 this cycle; wr_count increments; next state is IDLE.
  - Load: sram_re = 1; stall = 1; next state is RESP.
- ACCESS, out of range:
  - No SRAM strobe is driven.
  - Store: the store is dropped, bus_err = 1, stall = 0, wr_count still increments, next state is IDLE.
  - Load: go to RESP with the error flag set.
- RESP:
  - mrd is driven with sram_rdata, or with ERR_DATA if the error flag is set.
  - stall = 0 and rd_count increments.
  - bus_err = 1 if the error flag is set.
  - Next state is IDLE.
  - mrd holds its value until the next load reaches RESP.
- Cycle counts with W = WAIT_STATES:
  - A load holds stall high for W+2 cycles and completes in cycle W+2 (0-based).
  - A store holds stall high for W+1 cycles.
- The Beta's request is still asserted during the final stall=0 cycle. This does not retrigger, because the FSM is not in IDLE. A new request is accepted on the following cycle, giving back-to-back accesses with no bubble.
- The latched address and data are used for the access. Changes on ma/mwd after acceptance are ignored.
- Counters saturate: at 16'hFFFF a further increment holds the value.
- Only one request is outstanding at a time; there is no buffering beyond the latch.

Test Plan:
1. Reset then idle: RST pulsed for 3 cycles with moe = wr = 0 → all outputs 0, state IDLE, no SRAM strobes.
2. Store then load, WAIT_STATES = 2: wr=1, ma=32'h10, mwd=32'hCAFE_0001 → stall high for 3 cycles, sram_we on address 4. Next, moe=1, ma=32'h10 → stall high for 4 cycles, mrd=32'hCAFE_0001, rd_count=1, wr_count=1.
3. WAIT_STATES = 0, back-to-back loads at 32'h0 and 32'h4 → each load stalls for exactly 2 cycles with no idle cycle between them, and mrd returns the correct word for each.
4. Out-of-range load, DEPTH = 1024: ma=32'h1000 → no sram_re, mrd=32'hDEAD_BEEF, bus_err pulses 1 cycle in RESP. An out-of-range store → no sram_we and a bus_err pulse.
5. Simultaneous moe=1 and wr=1 → treated as a store: sram_we pulses, sram_re never pulses, wr_count increments and rd_count does not.
6. RST asserted during BUSY of a store → stall drops immediately, no sram_we ever pulses, counters read 0, and the next request after reset completes normally.
